// File: rtl/denorm_shifter.sv
// rtl/denorm_shifter.sv - iterative denormalizer: coarse 8-bit then fine 1-bit shifts, saturating left shift
module denorm_shifter #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic [6:0]       i_shift,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_sat
);

    localparam logic [7:0] WIDTH_L = 8'(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [6:0]       rem_q, rem_d;
    logic             right_q, right_d;
    logic             sat_q, sat_d;

    logic [6:0]       mag;
    logic             big_step;
    logic [6:0]       step;
    logic [WIDTH-1:0] shifted;
    logic             ovf;

    // Magnitude of the two's-complement count; -64 maps to 64 in 7 bits.
    assign mag      = i_shift[6] ? (~i_shift + 7'd1) : i_shift;
    assign big_step = (rem_q >= 7'd8);
    assign step     = big_step ? 7'd8 : 7'd1;

    always_comb begin
        shifted = work_q;
        ovf     = 1'b0;
        if (right_q) begin
            shifted = big_step ? (work_q >> 8) : (work_q >> 1);
        end else begin
            shifted = big_step ? (work_q << 8) : (work_q << 1);
            ovf     = big_step ? (|work_q[WIDTH-1 -: 8]) : work_q[WIDTH-1];
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        data_d  = data_q;
        rem_d   = rem_q;
        right_d = right_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    right_d = ~i_shift[6];
                    if (mag == 7'd0) begin
                        data_d  = i_data;
                        sat_d   = 1'b0;
                        state_d = DONE;
                    end else if ({1'b0, mag} >= WIDTH_L) begin
                        // Everything shifts out: only a nonzero left shift saturates.
                        if (~i_shift[6] || (i_data == '0)) begin
                            data_d = '0;
                            sat_d  = 1'b0;
                        end else begin
                            data_d = '1;
                            sat_d  = 1'b1;
                        end
                        state_d = DONE;
                    end else begin
                        work_d  = i_data;
                        rem_d   = mag;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d = shifted;
                rem_d  = rem_q - step;
                if (ovf) begin
                    data_d  = '1;
                    sat_d   = 1'b1;
                    state_d = DONE;
                end else if (rem_q == step) begin
                    data_d  = shifted;
                    sat_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            data_q  <= '0;
            rem_q   <= '0;
            right_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            right_q <= right_d;
            sat_q   <= sat_d;
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_valid = (state_q == DONE);
    assign o_data  = data_q;
    assign o_sat   = sat_q;

endmodule

// File: tb/tb_denorm_shifter.sv
// tb/tb_denorm_shifter.sv - vector table, corner sequences and randomized model check for denorm_shifter
module tb_denorm_shifter;

    localparam int W = 24;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [W-1:0]  i_data = '0;
    logic [6:0]    i_shift = '0;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [W-1:0]  o_data;
    logic          o_sat;

    int checks = 0;
    int errors = 0;

    denorm_shifter #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_shift (i_shift),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_sat   (o_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic [6:0]   shift;
        logic [W-1:0] exp_data;
        logic         exp_sat;
        int           exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic plus an explicit list of step sizes to locate the overflow step.
    function automatic void model(input logic [W-1:0] d, input logic [6:0] sh,
                                  output logic [W-1:0] ed, output logic es, output int el);
        int mag, n8, n1, cum;
        bit right;
        logic [127:0] wide;
        right = !sh[6];
        mag   = right ? int'(sh) : 128 - int'(sh);
        n8    = mag / 8;
        n1    = mag % 8;
        es    = 1'b0;
        el    = 1;
        ed    = '0;
        if (mag == 0) begin
            ed = d;
        end else if (mag >= W) begin
            if (!right && d != '0) begin
                ed = '1;
                es = 1'b1;
            end
        end else if (right) begin
            ed = W'(d >> mag);
            el = n8 + n1 + 1;
        end else begin
            ed = W'(d << mag);
            el = n8 + n1 + 1;
            cum = 0;
            for (int j = 1; j <= n8 + n1; j++) begin
                cum += (j <= n8) ? 8 : 1;
                wide = {104'b0, d} << cum;
                if (wide[127:W] != '0) begin
                    ed = '1;
                    es = 1'b1;
                    el = j + 1;
                    break;
                end
            end
        end
    endfunction

    task automatic run_op(input logic [W-1:0] d, input logic [6:0] sh,
                          output logic [W-1:0] gd, output logic gs, output int lat);
        i_data  = d;
        i_shift = sh;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_data  = $urandom;
        i_shift = 7'($urandom);
        lat = 1;
        while (!o_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        gd = o_data;
        gs = o_sat;
    endtask

    task automatic accept_result;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        chk("ready_after_accept", {63'b0, o_ready}, 64'd1);
        chk("valid_after_accept", {63'b0, o_valid}, 64'd0);
    endtask

    vec_t vecs[13];

    initial begin
        logic [W-1:0] gd, ed, held;
        logic         gs, es;
        int           lat, el;

        vecs[0]  = '{24'h800000, 7'd12,    24'h000800, 1'b0, 6};
        vecs[1]  = '{24'h000001, 7'h69,    24'h800000, 1'b0, 10};
        vecs[2]  = '{24'h00FF00, 7'h74,    24'hFFFFFF, 1'b1, 3};
        vecs[3]  = '{24'h123456, 7'd0,     24'h123456, 1'b0, 1};
        vecs[4]  = '{24'hABCDEF, 7'd30,    24'h000000, 1'b0, 1};
        vecs[5]  = '{24'h000000, 7'h58,    24'h000000, 1'b0, 1};
        vecs[6]  = '{24'h000001, 7'h40,    24'hFFFFFF, 1'b1, 1};
        vecs[7]  = '{24'h800000, 7'd23,    24'h000001, 1'b0, 10};
        vecs[8]  = '{24'h000001, 7'h68,    24'hFFFFFF, 1'b1, 1};
        vecs[9]  = '{24'hFFFFFF, 7'd24,    24'h000000, 1'b0, 1};
        vecs[10] = '{24'h800000, 7'h7F,    24'hFFFFFF, 1'b1, 2};
        vecs[11] = '{24'h000000, 7'h6C,    24'h000000, 1'b0, 7};
        vecs[12] = '{24'hFEDCBA, 7'd63,    24'h000000, 1'b0, 1};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_o_ready", {63'b0, o_ready}, 64'd1);
        chk("reset_o_valid", {63'b0, o_valid}, 64'd0);
        chk("reset_o_data", {40'b0, o_data}, 64'd0);
        chk("reset_o_sat", {63'b0, o_sat}, 64'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].data, vecs[i].shift, gd, gs, lat);
            chk($sformatf("vec%0d_data", i), {40'b0, gd}, {40'b0, vecs[i].exp_data});
            chk($sformatf("vec%0d_sat", i), {63'b0, gs}, {63'b0, vecs[i].exp_sat});
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
            accept_result();
        end

        // Backpressure: result must hold and new requests must be ignored.
        run_op(24'h0F0F0F, 7'd4, gd, gs, lat);
        chk("bp_data", {40'b0, gd}, 64'h00F0F0);
        held = o_data;
        i_valid = 1'b1;
        i_data  = 24'h000001;
        i_shift = 7'h40;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp_valid_held", {63'b0, o_valid}, 64'd1);
            chk("bp_ready_low", {63'b0, o_ready}, 64'd0);
            chk("bp_data_stable", {40'b0, o_data}, {40'b0, held});
            chk("bp_sat_stable", {63'b0, o_sat}, 64'd0);
        end
        i_valid = 1'b0;
        accept_result();
        chk("bp_data_kept", {40'b0, o_data}, {40'b0, held});

        // Reset in the middle of a right shift by 20 (six steps).
        i_data  = 24'hFFFFFF;
        i_shift = 7'd20;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_busy", {63'b0, o_ready}, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_rst_ready", {63'b0, o_ready}, 64'd1);
        chk("mid_rst_valid", {63'b0, o_valid}, 64'd0);
        chk("mid_rst_data", {40'b0, o_data}, 64'd0);
        chk("mid_rst_sat", {63'b0, o_sat}, 64'd0);
        run_op(24'h400000, 7'd10, gd, gs, lat);
        chk("post_rst_data", {40'b0, gd}, 64'h001000);
        chk("post_rst_lat", 64'(lat), 64'd4);
        accept_result();

        for (int r = 0; r < 200; r++) begin
            logic [W-1:0] d;
            logic [6:0]   sh;
            case ($urandom_range(0, 3))
                0:       d = W'($urandom_range(0, 255));
                1:       d = (r % 5 == 0) ? '0 : W'($urandom) >> $urandom_range(0, 23);
                default: d = W'($urandom);
            endcase
            sh = 7'($urandom_range(0, 127));
            model(d, sh, ed, es, el);
            run_op(d, sh, gd, gs, lat);
            chk($sformatf("rnd%0d_data d=%h sh=%h", r, d, sh), {40'b0, gd}, {40'b0, ed});
            chk($sformatf("rnd%0d_sat", r), {63'b0, gs}, {63'b0, es});
            chk($sformatf("rnd%0d_lat", r), 64'(lat), 64'(el));
            accept_result();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/denorm_shifter.md
Name: denorm_shifter

Overview:
- Denormalizer: the inverse of the leading-zero count / normalize step in the reciprocal datapath.
- Takes a normalized mantissa and a signed shift count (typically derived from an lzc count) and restores the fixed-point result.
- Shifts right to denormalize or left to rescale; left-shift overflow saturates.
- Iterative and multi-cycle: 8-bit coarse steps, then 1-bit fine steps, to keep area small. Valid/ready handshakes on both sides.

Parameters:
- WIDTH, 24, data width in bits (Q12.12); supported range 8..64.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_valid  in  1  input request valid.
- o_ready  out  1  block can accept a request; high only in IDLE.
- i_data  in  WIDTH  unsigned normalized mantissa.
- i_shift  in  7  signed two's-complement shift; positive = shift right, negative = shift left, range -64..+63.
- o_valid  out  1  result valid; held until accepted.
- i_ready  in  1  downstream accepts result.
- o_data  out  WIDTH  shifted result.
- o_sat  out  1  result saturated by left-shift overflow.

Behaviour:
- Reset (synchronous, active-high; wins over every other event):
  - state=IDLE, o_ready=1, o_valid=0, o_data=0, o_sat=0, internal counters cleared.
  - Reset asserted mid-SHIFT or in DONE discards the operation; IDLE on the next edge.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - o_ready=1.
  - On an edge with i_valid=1, capture i_data, direction = sign of i_shift, and mag = |i_shift| (7-bit unsigned; -64 gives 64).
  - If mag==0: o_data=i_data, o_sat=0, go to DONE.
  - If mag>=WIDTH:
    - right shift: o_data=0, o_sat=0.
    - left shift with i_data==0: o_data=0, o_sat=0.
    - left shift with i_data!=0: o_data=all ones, o_sat=1.
    - In all three cases go to DONE.
  - Otherwise load the working register, set remaining=mag, go to SHIFT.
- SHIFT: one step per cycle; o_ready=0, o_valid=0.
  - If remaining>=8, shift 8 bits; else shift 1 bit. Decrement remaining by the step size.
  - Right shifts: zero-fill from MSB, discarded LSBs truncated (round toward zero).
  - Left shifts: zero-fill from LSB. If any 1 bit is shifted out above bit WIDTH-1, set o_data=all ones, o_sat=1 and go to DONE immediately (early exit).
  - When remaining reaches 0 after a step: o_data = working register, go to DONE.
  - Step count N = (mag>>3) + (mag&7), for 0<mag<WIDTH.
- Latency:
  - o_valid rises N+1 edges after the accepting edge; N=0 covers mag==0 and mag>=WIDTH.
  - Saturating left shift: k+1 edges, where k is the step that overflowed.
- DONE:
  - o_valid=1; o_data and o_sat stable while i_ready=0.
  - On an edge with i_ready=1: o_valid=0, go to IDLE. o_data and o_sat keep their last values until the next result.
  - Maximum throughput is one request per N+3 cycles.
- Request gating: i_valid is ignored outside IDLE; i_data and i_shift are don't-care when not captured.
- Zero data: i_data==0 never saturates; the result is 0 for any shift.

Test Plan:
- Reset state: reset for 2 cycles -> o_ready=1, o_valid=0, o_data=0, o_sat=0. Then i_data=0x800000, i_shift=+12 -> o_data=0x000800, o_sat=0, o_valid 6 edges after accept (N=5).
- Left shift, no overflow: i_data=0x000001, i_shift=-23 -> o_data=0x800000, o_sat=0, o_valid 10 edges after accept (N=9).
- Early saturation: i_data=0x00FF00, i_shift=-12 -> after the 8-bit step 0xFF0000, the 1-bit step overflows -> o_data=0xFFFFFF, o_sat=1, o_valid 3 edges after accept.
- Zero and out-of-range shifts, each with o_valid 1 edge after accept:
  - i_shift=0, i_data=0x123456 -> 0x123456.
  - i_shift=+30, i_data=0xABCDEF -> 0x000000.
  - i_shift=-40, i_data=0 -> 0, o_sat=0.
  - i_shift=-64, i_data=0x000001 -> 0xFFFFFF, o_sat=1.
- Backpressure: result ready with i_ready=0 for 5 cycles while i_valid=1 with new data -> o_data/o_sat stable, o_ready=0, new request not captured. i_ready=1 -> IDLE next edge, o_ready=1.
- Reset mid-operation: assert reset during SHIFT (i_shift=+20) -> next edge state IDLE, o_valid=0, o_data=0. A new request completes normally afterwards.
